// File: rtl/msg_checker.sv
// Avalon-ST sink for the debug word generator: checks framing, length and
// all-zero payload, and keeps saturating counters and sticky flags for readout.
module msg_checker #(
  parameter int          DATA_WIDTH        = 128,
  parameter int          WORD_COUNTER_SIZE = 8,
  parameter int          CNT_WIDTH         = 32,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter int          EMPTY_WIDTH       = $clog2(DATA_WIDTH / 8)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        msg_data_i,
  input  logic                         msg_valid_i,
  output logic                         msg_ready_o,
  input  logic                         msg_sop_i,
  input  logic                         msg_eop_i,
  input  logic [EMPTY_WIDTH-1:0]       msg_empty_i,
  input  logic [WORD_COUNTER_SIZE-1:0] exp_word_cnt_i,
  input  logic                         bp_en_i,
  input  logic                         clear_i,
  output logic [CNT_WIDTH-1:0]         pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o,
  output logic [3:0]                   err_flags_o,
  output logic [WORD_COUNTER_SIZE-1:0] last_len_o,
  output logic                         pkt_done_o,
  output logic                         in_pkt_o
);

  localparam int WCS = WORD_COUNTER_SIZE;
  localparam logic [WCS-1:0] IDX_MAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e               state_q, state_d;
  logic [WCS-1:0]       idx_q, idx_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, err_cnt_q;
  logic [3:0]           err_flags_q, err_d;
  logic [WCS-1:0]       last_len_q, len_d;
  logic                 pkt_done_q, in_pkt_q;
  logic                 accept, complete, sat;

  assign msg_ready_o = ~bp_en_i | lfsr_q[0];
  assign accept      = msg_valid_i & msg_ready_o;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    complete = 1'b0;
    sat      = 1'b0;
    len_d    = '0;
    err_d    = '0;
    // Fibonacci LFSR, taps 16,14,13,11
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    if (accept) begin
      err_d[3] = (|msg_data_i) | (|msg_empty_i);
      case (state_q)
        IDLE: begin
          if (!msg_sop_i) begin
            err_d[0] = 1'b1;
          end else if (msg_eop_i) begin
            complete = 1'b1;
            len_d    = WCS'(1);
          end else begin
            state_d = IN_PKT;
            idx_d   = WCS'(1);
          end
        end
        IN_PKT: begin
          if (msg_sop_i) begin
            // restart on the offending sop beat
            err_d[1] = 1'b1;
            if (msg_eop_i) begin
              complete = 1'b1;
              len_d    = WCS'(1);
              state_d  = IDLE;
              idx_d    = '0;
            end else begin
              idx_d = WCS'(1);
            end
          end else if (msg_eop_i) begin
            complete = 1'b1;
            sat      = (idx_q == IDX_MAX);
            len_d    = sat ? IDX_MAX : idx_q + WCS'(1);
            state_d  = IDLE;
            idx_d    = '0;
          end else begin
            idx_d = (idx_q == IDX_MAX) ? IDX_MAX : idx_q + WCS'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
      if (complete && (exp_word_cnt_i != '0) && ((len_d != exp_word_cnt_i) || sat))
        err_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      last_len_q  <= '0;
      pkt_done_q  <= 1'b0;
      in_pkt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      pkt_done_q <= complete;
      in_pkt_q   <= (state_d == IN_PKT);
      if (clear_i) begin
        pkt_cnt_q   <= '0;
        err_cnt_q   <= '0;
        err_flags_q <= '0;
        last_len_q  <= '0;
      end else begin
        if (complete) begin
          last_len_q <= len_d;
          if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
        end
        if ((|err_d) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
        err_flags_q <= err_flags_q | err_d;
      end
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_flags_o = err_flags_q;
  assign last_len_o  = last_len_q;
  assign pkt_done_o  = pkt_done_q;
  assign in_pkt_o    = in_pkt_q;

endmodule

// File: tb/tb_msg_checker.sv
// Directed table-driven bench for msg_checker plus sequences for saturation,
// reset mid-packet and LFSR backpressure.
module tb_msg_checker;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data;
  logic         valid, ready, sop, eop;
  logic [3:0]   empty;
  logic [7:0]   exp_cnt;
  logic         bp_en, clear;
  logic [31:0]  pkt_cnt, err_cnt;
  logic [3:0]   err_flags;
  logic [7:0]   last_len;
  logic         pkt_done, in_pkt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msg_checker dut (
    .clk_i(clk), .rst_i(rst),
    .msg_data_i(data), .msg_valid_i(valid), .msg_ready_o(ready),
    .msg_sop_i(sop), .msg_eop_i(eop), .msg_empty_i(empty),
    .exp_word_cnt_i(exp_cnt), .bp_en_i(bp_en), .clear_i(clear),
    .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt), .err_flags_o(err_flags),
    .last_len_o(last_len), .pkt_done_o(pkt_done), .in_pkt_o(in_pkt)
  );

  typedef struct {
    logic       v, s, e;
    logic [7:0] d;
    logic [3:0] em;
    logic       clr;
    logic [7:0] ex;
    logic [31:0] pc, ec;
    logic [3:0] fl;
    logic [7:0] ll;
    logic       pd, ip;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input logic v, s, e, input logic [7:0] d, input logic [3:0] em,
                     input logic clr, input logic [7:0] ex,
                     input logic [31:0] pc, ec, input logic [3:0] fl,
                     input logic [7:0] ll, input logic pd, ip);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.d = d; r.em = em; r.clr = clr; r.ex = ex;
    r.pc = pc; r.ec = ec; r.fl = fl; r.ll = ll; r.pd = pd; r.ip = ip;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, s, e, input logic [7:0] d, input logic [3:0] em,
                       input logic clr);
    @(negedge clk);
    valid = v; sop = s; eop = e; data = {120'b0, d}; empty = em; clear = clr;
  endtask

  task automatic beat(input logic v, s, e, input logic [7:0] d, input logic clr);
    drive(v, s, e, d, 4'd0, clr);
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] pc, ec,
                            input logic [3:0] fl, input logic [7:0] ll, input logic pd, ip);
    chk({tag, ".pkt_cnt"}, pkt_cnt, pc);
    chk({tag, ".err_cnt"}, err_cnt, ec);
    chk({tag, ".err_flags"}, err_flags, fl);
    chk({tag, ".last_len"}, last_len, ll);
    chk({tag, ".pkt_done"}, pkt_done, pd);
    chk({tag, ".in_pkt"}, in_pkt, ip);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  initial begin
    rst = 1'b1; data = '0; valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0;
    exp_cnt = 8'd4; bp_en = 1'b0; clear = 1'b0;

    //  v  s  e  d  em clr ex   pc ec fl ll pd ip
    add(1, 1, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 4,   1, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0, 4,   1, 0, 0, 4, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4,   1, 0, 0, 4, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   1, 0, 0, 4, 0, 1);
    add(1, 0, 1, 0, 0, 0, 4,   2, 1, 4, 3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 4,   0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4,   0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 1, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 4,   1, 1, 1, 4, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 4,   0, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4,   0, 1, 2, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 4,   1, 1, 2, 4, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4,   1, 1, 4, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0,   2, 1, 4, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 2, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0,   2, 1, 8, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0,   2, 2, 9, 1, 0, 0);
    add(1, 1, 1, 0, 3, 0, 0,   3, 3, 9, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0,   3, 3, 9, 1, 0, 0);

    @(posedge clk); #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      exp_cnt = tbl[i].ex;
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].em, tbl[i].clr);
      chk($sformatf("vec%0d.ready", i), ready, 1'b1);
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ec, tbl[i].fl,
                 tbl[i].ll, tbl[i].pd, tbl[i].ip);
    end

    // 300-beat packet: index saturates, LEN even though length equals exp
    exp_cnt = 8'd255;
    beat(0, 0, 0, 0, 1);
    beat(1, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) beat(1, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0);
    check_outs("sat300", 1, 1, 4'h4, 8'd255, 1, 0);

    // exactly 255 beats: largest unsaturated length, no error
    beat(0, 0, 0, 0, 1);
    beat(1, 1, 0, 0, 0);
    for (int i = 0; i < 253; i++) beat(1, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0);
    check_outs("len255", 1, 0, 4'h0, 8'd255, 1, 0);

    // data error mid-packet, then reset abandons the packet
    exp_cnt = 8'd4;
    beat(0, 0, 0, 0, 1);
    beat(1, 1, 0, 0, 0);
    beat(1, 0, 0, 1, 0);
    check_outs("data_mid", 0, 1, 4'h8, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0);
    beat(1, 1, 1, 0, 1);
    chk("clr_beat.pkt_cnt", pkt_cnt, 0);
    chk("clr_beat.err_cnt", err_cnt, 0);
    chk("clr_beat.last_len", last_len, 0);
    beat(0, 0, 0, 0, 0);

    // backpressure: 100 x 8-beat messages against an LFSR model
    begin
      logic [15:0] m;
      int bi, sent, mism, cyc;
      bit saw_lo, saw_hi;
      exp_cnt = 8'd8;
      do_reset();
      bp_en = 1'b1;
      m = 16'hACE1; bi = 0; sent = 0; mism = 0; cyc = 0; saw_lo = 0; saw_hi = 0;
      while (sent < 100 && cyc < 5000) begin
        if (cyc != 0) @(negedge clk);
        if (ready !== m[0]) mism++;
        if (m[0]) saw_hi = 1; else saw_lo = 1;
        valid = 1'b1; sop = (bi == 0); eop = (bi == 7); data = '0; empty = '0; clear = 1'b0;
        @(posedge clk);
        if (m[0]) begin
          bi++;
          if (bi == 8) begin bi = 0; sent++; end
        end
        m = lfsr_next(m);
        cyc++;
      end
      @(negedge clk);
      valid = 1'b0;
      @(posedge clk); #1;
      chk("bp.sent", sent, 100);
      chk("bp.ready_mismatches", mism, 0);
      chk("bp.ready_toggles", {saw_lo, saw_hi}, 2'b11);
      chk("bp.pkt_cnt", pkt_cnt, 100);
      chk("bp.err_flags", err_flags, 0);
      chk("bp.err_cnt", err_cnt, 0);
      chk("bp.last_len", last_len, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msg_checker.md
Name: msg_checker

Overview:
- Avalon-ST sink placed directly downstream of the on-board debug word generator. It consumes generated messages and checks their framing, length and payload.
- Maintains packet/error counters, sticky error flags and last measured length for debug readout.
- Optional LFSR-driven backpressure exercises the upstream ready handling.

Parameters:
- DATA_WIDTH, 128, width of msg_in.data.
- WORD_COUNTER_SIZE, 8, width of the word index and length fields.
- CNT_WIDTH, 32, width of the packet and error counters.
- LFSR_SEED, 16'hACE1, reset value of the backpressure LFSR (must be non-zero).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- msg_in  avalon_st_if.slave  -  stream input (data, valid, ready, sop, eop, empty).
- exp_word_cnt  input  WORD_COUNTER_SIZE  expected words per message; 0 disables the length check.
- bp_en  input  1  enables pseudo-random backpressure.
- clear  input  1  synchronous clear of counters, flags and last_len.
- pkt_cnt  output  CNT_WIDTH  completed packets (accepted eop beats), saturating.
- err_cnt  output  CNT_WIDTH  error events, saturating.
- err_flags  output  4  sticky: [0] NO_SOP, [1] SOP_MID, [2] LEN, [3] DATA.
- last_len  output  WORD_COUNTER_SIZE  length of the most recent completed packet.
- pkt_done  output  1  one-cycle pulse on an accepted eop.
- in_pkt  output  1  high while in the IN_PKT state.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, word index=0, lfsr=LFSR_SEED.
  - pkt_cnt=0, err_cnt=0, err_flags=0, last_len=0, pkt_done=0, in_pkt=0.
  - Reset mid-packet abandons the packet silently; no error is recorded.
- Ready:
  - msg_in.ready = ~bp_en | lfsr[0], combinational from registered state.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle regardless of traffic and does not react to clear.
- Accepted beat = valid & ready. Only accepted beats change checker state. Valid without ready changes nothing.
- Data check on every accepted beat:
  - data != 0 or empty != 0 -> DATA error.
  - This check is independent of framing.
- FSM IDLE:
  - Beat with sop & eop -> single-word packet: length=1, stay IDLE.
  - Beat with sop & ~eop -> IN_PKT, index=1.
  - Beat with ~sop -> NO_SOP error, beat dropped, stay IDLE.
- FSM IN_PKT:
  - Beat with ~sop & ~eop -> index+1, saturating at all-ones.
  - Beat with ~sop & eop -> length=index+1 (saturating), go to IDLE.
  - Beat with sop -> SOP_MID error; restart the packet on this beat (index=1, or complete as a single-word packet if eop is also set).
- Packet completion (accepted eop, not dropped):
  - pkt_done=1 next cycle.
  - pkt_cnt+1, last_len=length.
  - LEN error if exp_word_cnt != 0 and (length != exp_word_cnt or index was saturated).
- Error accounting:
  - Each error type sets its flag bit (sticky until clear or rst).
  - err_cnt increments by 1 per beat carrying one or more errors, not per error type.
- Outputs are registered and updated one cycle after the accepted beat.
- Counters saturate at all-ones; no wrap.
- clear has lower priority than rst. A beat accepted in the same cycle as clear is ignored for counters, flags and last_len, but still advances the FSM.
- exp_word_cnt is sampled at the eop beat; changing it mid-packet is legal.

Test Plan:
- bp_en=0, exp=4, four accepted beats with sop on beat0, eop on beat3, data=0 -> pkt_cnt=1, last_len=4, err_flags=0, pkt_done pulses once, ready constantly 1.
- exp=4, three-beat packet (sop, -, eop) -> LEN flag set, err_cnt=1, pkt_cnt=1, last_len=3.
- In IDLE, beat without sop, then a valid 4-beat packet -> NO_SOP set, err_cnt=1, pkt_cnt=1, last_len=4.
- sop at beat0, sop again at beat2, eop at beat5 -> SOP_MID set, err_cnt=1, last_len=4, pkt_cnt=1.
- bp_en=1, 100 back-to-back 8-beat messages, exp=8 -> ready toggles matching the LFSR sequence from 16'hACE1, pkt_cnt=100, err_flags=0.
- Beat with data=1 mid-packet; assert rst mid-packet; then clear -> DATA flag set and err_cnt=1 before reset; after rst all outputs 0, in_pkt=0; clear with a concurrent beat leaves the counters at 0.
